// File: rtl/mont_precompute_pkg.sv
// rtl/mont_precompute_pkg.sv - shared widths, types and helpers for the Montgomery precompute block
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

package mont_precompute_pkg;

    localparam int unsigned WORD_W = `BITS;
    localparam int unsigned CNT_W  = `LOG_BITS;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Montgomery arithmetic needs an odd modulus above one.
    function automatic logic is_bad_modulus(input word_t n);
        return (!n[0]) || (n < word_t'(2));
    endfunction

endpackage

// File: rtl/mont_precompute_if.sv
// rtl/mont_precompute_if.sv - request/result bundle between a requester and mont_precompute
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

interface mont_precompute_if
    import mont_precompute_pkg::*;
    ();

    logic  start;
    word_t base;
    word_t N;
    logic  done;
    logic  err;
    word_t base_mont;
    word_t one_mont;
    word_t N_prime;

    modport master (
        output start, base, N,
        input  done, err, base_mont, one_mont, N_prime
    );

    modport slave (
        input  start, base, N,
        output done, err, base_mont, one_mont, N_prime
    );

endinterface

// File: rtl/mont_precompute_mod_double.sv
// rtl/mont_precompute_mod_double.sv - combinational modular doubling, 2x mod N for x < N
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

module mod_double
    import mont_precompute_pkg::*;
(
    input  word_t x,
    input  word_t N,
    output word_t y
);

    // One extra bit keeps the carry of 2x so the compare against N is exact.
    logic [`BITS:0] w_dbl;
    logic [`BITS:0] w_n_ext;

    assign w_dbl   = {x, 1'b0};
    assign w_n_ext = {1'b0, N};
    assign y       = (w_dbl >= w_n_ext) ? word_t'(w_dbl - w_n_ext) : w_dbl[`BITS-1:0];

endmodule

// File: rtl/mont_precompute.sv
// rtl/mont_precompute.sv - computes base*R mod N, R mod N and -1/N mod R for R = 2^BITS
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

module mont_precompute
    import mont_precompute_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mont_precompute_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    word_t r_n;
    word_t r_b;
    word_t r_r;
    word_t r_y;
    word_t r_s;
    cnt_t  r_cnt;
    logic  r_err;

    word_t w_r_dbl;
    word_t w_b_dbl;
    word_t w_n_shl;
    logic  w_last;
    logic  w_bad;
    logic  w_done;

    mod_double u_dbl_r (
        .x (r_r),
        .N (r_n),
        .y (w_r_dbl)
    );

    mod_double u_dbl_b (
        .x (r_b),
        .N (r_n),
        .y (w_b_dbl)
    );

    assign w_last  = (r_cnt == cnt_t'(`BITS - 1));
    assign w_bad   = is_bad_modulus(bus.N);
    assign w_n_shl = r_n << r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = w_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_done = 1'b0;
        if (r_state == ST_DONE) begin
            w_done = 1'b1;
        end
    end

    // Bit i of N_prime is set whenever bit i of the running N*N_prime is still
    // zero, so after BITS steps the product is all ones, i.e. -1 mod 2^BITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_y   <= '0;
            r_s   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_n   <= bus.N;
                        r_y   <= '0;
                        r_s   <= '0;
                        r_cnt <= '0;
                        if (w_bad) begin
                            r_b   <= '0;
                            r_r   <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_b   <= bus.base;
                            r_r   <= word_t'(1);
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_r <= w_r_dbl;
                    r_b <= w_b_dbl;
                    if (!r_s[r_cnt]) begin
                        r_y[r_cnt] <= 1'b1;
                        r_s        <= r_s + w_n_shl;
                    end
                    r_cnt <= w_last ? '0 : r_cnt + cnt_t'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.base_mont = r_b;
    assign bus.one_mont  = r_r;
    assign bus.N_prime   = r_y;

endmodule

// File: tb/tb_mont_precompute.sv
// tb/tb_mont_precompute.sv - table-driven scoreboard bench for mont_precompute at BITS=8
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

module tb_mont_precompute;

    typedef struct {
        logic [7:0] n;
        logic [7:0] base;
        logic [7:0] one;
        logic [7:0] bm;
        logic [7:0] np;
        logic       err;
    } vec_t;

    typedef struct {
        vec_t v;
        int   samp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mont_precompute_if bus ();

    mont_precompute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    exp_t sb[$];
    vec_t tbl[8];
    logic [7:0] cap_one, cap_bm, cap_np;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mont_mul(input int a, input int b, input int n, input int np);
        int t, m, u;
        t = a * b;
        m = ((t & 255) * np) & 255;
        u = (t + m * n) >> 8;
        if (u >= n) u = u - n;
        return u;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard consumer: every done pulse must match the oldest pending request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.samp, e.v.err ? 0 : 8);
                    chk("one_mont", int'(bus.one_mont), int'(e.v.one));
                    chk("base_mont", int'(bus.base_mont), int'(e.v.bm));
                    chk("N_prime", int'(bus.N_prime), int'(e.v.np));
                    chk("err", int'(bus.err), int'(e.v.err));
                    cap_one = bus.one_mont;
                    cap_bm  = bus.base_mont;
                    cap_np  = bus.N_prime;
                end
            end
        end
    end

    task automatic do_run(input vec_t v, input bit hold);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.N     = v.n;
        bus.base  = v.base;
        sb.push_back('{v: v, samp: cyc + 1});
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("hold_one_mont", int'(bus.one_mont), int'(v.one));
        chk("hold_err", int'(bus.err), int'(v.err));
    endtask

    initial begin
        int x;
        int pend;
        tbl[0] = '{n: 8'd13,  base: 8'd5,   one: 8'd9,  bm: 8'd6,   np: 8'd59,  err: 1'b0};
        tbl[1] = '{n: 8'd255, base: 8'd254, one: 8'd1,  bm: 8'd254, np: 8'd1,   err: 1'b0};
        tbl[2] = '{n: 8'd12,  base: 8'd3,   one: 8'd0,  bm: 8'd0,   np: 8'd0,   err: 1'b1};
        tbl[3] = '{n: 8'd1,   base: 8'd0,   one: 8'd0,  bm: 8'd0,   np: 8'd0,   err: 1'b1};
        tbl[4] = '{n: 8'd3,   base: 8'd2,   one: 8'd1,  bm: 8'd2,   np: 8'd85,  err: 1'b0};
        tbl[5] = '{n: 8'd101, base: 8'd77,  one: 8'd54, bm: 8'd17,  np: 8'd147, err: 1'b0};
        tbl[6] = '{n: 8'd7,   base: 8'd6,   one: 8'd4,  bm: 8'd3,   np: 8'd73,  err: 1'b0};
        tbl[7] = '{n: 8'd0,   base: 8'd0,   one: 8'd0,  bm: 8'd0,   np: 8'd0,   err: 1'b1};

        bus.start = 1'b0;
        bus.N     = 8'd0;
        bus.base  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_outputs", int'({bus.one_mont, bus.base_mont, bus.N_prime}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i], 1'b0);
        end

        // start held high for the whole run, then a fresh pulse starts run two
        do_run(tbl[0], 1'b1);
        repeat (4) @(negedge clk);
        do_run(tbl[1], 1'b0);

        // reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.N     = 8'd13;
        bus.base  = 8'd5;
        sb.push_back('{v: tbl[0], samp: cyc + 1});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_done", int'(bus.done), 0);
        chk("abort_outputs", int'({bus.one_mont, bus.base_mont, bus.N_prime}), 0);
        chk("abort_err", int'(bus.err), 0);
        pend = sb.size();
        chk("abort_pending", pend, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle_outputs", int'({bus.one_mont, bus.base_mont, bus.N_prime}), 0);
        do_run(tbl[0], 1'b0);

        // 5^3 mod 13 through a Montgomery exponentiation fed from the captured results
        x = int'(cap_one);
        for (int b = 1; b >= 0; b--) begin
            x = mont_mul(x, x, 13, int'(cap_np));
            if (b <= 1) x = mont_mul(x, int'(cap_bm), 13, int'(cap_np));
        end
        x = mont_mul(x, 1, 13, int'(cap_np));
        chk("exp_chain", x, 8);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mont_precompute.md
MONT_PRECOMPUTE -- requirements
Module: mont_precompute

Interface
REQ-001 Parameters: none; widths come from the shared `BITS and `LOG_BITS defines in defines.vh.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 base  input  `BITS  plain-domain base; precondition base < N.
REQ-006 N  input  `BITS  modulus; must be odd and > 1.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 err  output  1  high with done when N is even or N < 2; holds until next accepted start.
REQ-009 base_mont  output  `BITS  base*2^`BITS mod N.
REQ-010 one_mont  output  `BITS  2^`BITS mod N.
REQ-011 N_prime  output  `BITS  value with N*N_prime = -1 mod 2^`BITS.

Function
REQ-012 FSM states are IDLE, RUN and DONE.
REQ-013 IDLE with start=1: latch base and N.
  - N odd and N > 1: b=base, r=1, y=0, s=0, counter=0, go to RUN.
  - Otherwise: b=r=y=s=0, err=1, go straight to DONE.
REQ-014 Start in RUN or DONE is ignored, with no effect on any register.
REQ-015 RUN, per cycle i = counter, updated in parallel:
  - r <= moddbl(r).
  - b <= moddbl(b).
  - If s[i]==0: y[i] <= 1 and s <= (s + (N << i)) mod 2^`BITS.
REQ-016 moddbl(x) = 2x - N if 2x >= N, else 2x; computed with a `BITS+1-bit intermediate so no carry is lost.
REQ-017 RUN lasts exactly `BITS cycles. When counter == `BITS-1: go to DONE and wrap counter to 0.
REQ-018 Latency: done is high in the cycle after the (`BITS+1)th rising edge following the edge that sampled start. On the error path this is the cycle after the first edge.
REQ-019 DONE lasts exactly one cycle, then the FSM goes unconditionally to IDLE.
REQ-020 done = (state == DONE).
REQ-021 Output mapping: base_mont=b, one_mont=r, N_prime=y.
REQ-022 Outputs are valid while done is high and stay stable in IDLE until the next accepted start.
REQ-023 Outputs are undefined (intermediate values) during RUN.
REQ-024 done and start connect directly to the exponentiator's start. N_prime and one_mont are bit-compatible with its inputs.

Reset
REQ-025 rst=1 forces IDLE asynchronously, including mid-RUN.
REQ-026 Reset values: b, r, y, s, counter, err, done, and the latched base and N all 0.
REQ-027 An aborted computation produces no done pulse.
REQ-028 After rst deasserts, the first rising edge with start=1 begins a fresh computation.

Structure
REQ-029 `BITS and `LOG_BITS come from defines.vh; the counter is `LOG_BITS wide.
REQ-030 FSM state encodings are local to the module.
REQ-031 One combinational sub-module, mod_double (inputs x, N; output moddbl(x)), is instantiated twice, for r and b.
REQ-032 The N_prime adder stays inline.

Verification (bench built with `BITS=8)
REQ-033 N=13, base=5, start 1 cycle -> done after 9 edges, one_mont=9, base_mont=6, N_prime=59, err=0.
REQ-034 N=255, base=254 -> one_mont=1, base_mont=254, N_prime=1, err=0.
REQ-035 N=12 (then N=1) -> done one cycle after the start edge, err=1, all data outputs 0.
REQ-036 start held high throughout RUN with N=13 -> exactly one done pulse and correct results; a start pulse after return to IDLE starts a second run.
REQ-037 rst asserted at RUN cycle 4 -> immediate IDLE, all outputs 0, no done; a subsequent N=13/base=5 run gives the REQ-033 values.
REQ-038 Chain into montgomery_exp_square: N=13, base=5, exponent=3 -> exponentiator result converted out of the Montgomery domain equals 125 mod 13 = 8.
